// File: rtl/list_node_writer.sv
// list_node_writer
// Allocates 4-word linked-list nodes and streams them into the single
// synchronous write port of a 512 x 24-bit node memory. Node bases come from
// a LIFO stack of freed nodes first, then from a bump pointer over nodes that
// have never been handed out. Frees are accepted in any state.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   alloc_valid_i/alloc_ready_o/alloc_data_i   node write request (4 packed words)
//   done_valid_o/done_addr_o   one-cycle pulse with base of the node just written
//   free_valid_i/free_ready_o/free_addr_i      return a node (addr bits [1:0] ignored)
//   mem_we_o/mem_wa_o/mem_wd_o memory write port (address/data zero when idle)
//   full_o                     no node available
//   count_o                    nodes currently allocated
//
// state | meaning
// IDLE  | waiting for an allocation request
// WRITE | presenting word k_q of the latched node to the memory
// DONE  | node complete, done_valid_o asserted for one cycle
module list_node_writer #(
  parameter int MEM_SIZE  = 512,
  parameter int WORD_SIZE = 24,
  parameter int NUM_BITS  = $clog2(MEM_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_valid_i,
  output logic                   alloc_ready_o,
  input  logic [4*WORD_SIZE-1:0] alloc_data_i,
  output logic                   done_valid_o,
  output logic [NUM_BITS-1:0]    done_addr_o,
  input  logic                   free_valid_i,
  output logic                   free_ready_o,
  input  logic [NUM_BITS-1:0]    free_addr_i,
  output logic                   mem_we_o,
  output logic [NUM_BITS-1:0]    mem_wa_o,
  output logic [WORD_SIZE-1:0]   mem_wd_o,
  output logic                   full_o,
  output logic [7:0]             count_o
);

  localparam int NODES = MEM_SIZE / 4;
  localparam int IW    = NUM_BITS - 2;   // node index width
  localparam int PW    = IW + 1;         // sp/bp range 0..NODES

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                 state_q;
  logic [4*WORD_SIZE-1:0] data_q;
  logic [NUM_BITS-1:0]    base_q;
  logic [1:0]             k_q;
  logic                   mem_we_q;
  logic [NUM_BITS-1:0]    mem_wa_q;
  logic [WORD_SIZE-1:0]   mem_wd_q;
  logic                   done_valid_q;
  logic [NUM_BITS-1:0]    done_addr_q;
  logic [PW-1:0]          sp_q, sp_d;
  logic [PW-1:0]          bp_q, bp_d;
  logic [7:0]             count_q, count_d;
  logic [IW-1:0]          stack_q [NODES];

  logic          full;
  logic          alloc_acc, free_acc;
  logic [IW-1:0] sp_top, alloc_idx, free_idx, push_addr;
  logic [NUM_BITS-1:0] alloc_base;
  logic [1:0]    k_next;

  // Decoded from registered state only, so a same-cycle free cannot
  // unblock an allocation.
  assign full          = (sp_q == '0) && (bp_q == PW'(NODES));
  assign alloc_ready_o = (state_q == IDLE) && !full;
  assign free_ready_o  = (count_q != 8'd0);
  assign alloc_acc     = alloc_valid_i && alloc_ready_o;
  assign free_acc      = free_valid_i && free_ready_o;

  assign sp_top     = IW'(sp_q - PW'(1));
  assign alloc_idx  = (sp_q != '0) ? stack_q[sp_top] : bp_q[IW-1:0];
  assign alloc_base = {alloc_idx, 2'b00};
  assign free_idx   = IW'(free_addr_i >> 2);
  assign k_next     = k_q + 2'd1;

  always_comb begin
    sp_d      = sp_q;
    bp_d      = bp_q;
    count_d   = count_q;
    push_addr = sp_q[IW-1:0];
    if (alloc_acc) begin
      if (sp_q != '0) begin
        // Popping and pushing together: the freed index replaces the top.
        push_addr = sp_top;
        if (!free_acc) sp_d = sp_q - PW'(1);
      end else begin
        bp_d = bp_q + PW'(1);
      end
    end
    if (free_acc && !(alloc_acc && (sp_q != '0))) sp_d = sp_q + PW'(1);
    if (alloc_acc && !free_acc)      count_d = count_q + 8'd1;
    else if (free_acc && !alloc_acc) count_d = count_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (free_acc) stack_q[push_addr] <= free_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      base_q       <= '0;
      k_q          <= '0;
      mem_we_q     <= 1'b0;
      mem_wa_q     <= '0;
      mem_wd_q     <= '0;
      done_valid_q <= 1'b0;
      done_addr_q  <= '0;
      sp_q         <= '0;
      bp_q         <= '0;
      count_q      <= '0;
    end else begin
      sp_q    <= sp_d;
      bp_q    <= bp_d;
      count_q <= count_d;
      case (state_q)
        IDLE: begin
          if (alloc_acc) begin
            state_q  <= WRITE;
            data_q   <= alloc_data_i;
            base_q   <= alloc_base;
            k_q      <= 2'd0;
            mem_we_q <= 1'b1;
            mem_wa_q <= alloc_base;
            mem_wd_q <= alloc_data_i[WORD_SIZE-1:0];
          end
        end
        WRITE: begin
          if (k_q == 2'd3) begin
            state_q      <= DONE;
            mem_we_q     <= 1'b0;
            mem_wa_q     <= '0;
            mem_wd_q     <= '0;
            done_valid_q <= 1'b1;
            done_addr_q  <= base_q;
          end else begin
            k_q      <= k_next;
            mem_wa_q <= {base_q[NUM_BITS-1:2], k_next};
            mem_wd_q <= data_q[int'(k_next)*WORD_SIZE +: WORD_SIZE];
          end
        end
        DONE: begin
          state_q      <= IDLE;
          done_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_we_o     = mem_we_q;
  assign mem_wa_o     = mem_wa_q;
  assign mem_wd_o     = mem_wd_q;
  assign done_valid_o = done_valid_q;
  assign done_addr_o  = done_addr_q;
  assign full_o       = full;
  assign count_o      = count_q;

endmodule

// File: tb/tb_list_node_writer.sv
module tb_list_node_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [95:0] alloc_data = '0;
  logic        done_valid;
  logic [8:0]  done_addr;
  logic        free_valid = 1'b0;
  logic        free_ready;
  logic [8:0]  free_addr = '0;
  logic        mem_we;
  logic [8:0]  mem_wa;
  logic [23:0] mem_wd;
  logic        full;
  logic [7:0]  count;

  always #5 clk = ~clk;

  list_node_writer dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_data_i(alloc_data),
    .done_valid_o(done_valid), .done_addr_o(done_addr),
    .free_valid_i(free_valid), .free_ready_o(free_ready), .free_addr_i(free_addr),
    .mem_we_o(mem_we), .mem_wa_o(mem_wa), .mem_wd_o(mem_wd),
    .full_o(full), .count_o(count)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { logic [8:0] a; logic [23:0] d; bit last; } wr_t;
  wr_t        exp_wr[$];
  logic [8:0] exp_done[$];

  // Reference pool: LIFO of free node indices, bump pointer, live count.
  int m_stack[$];
  int m_bp;
  int m_count;
  int alloc_list[$];
  logic [8:0] last_done;
  bit expect_done_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_full();
    return (m_stack.size() == 0) && (m_bp == 128);
  endfunction

  // Monitor: every presented write and done pulse is popped and compared.
  always @(negedge clk) begin
    if (!rst_n) begin
      expect_done_next = 1'b0;
    end else begin
      chk("done_timing", done_valid, expect_done_next);
      expect_done_next = 1'b0;
      if (mem_we) begin
        if (exp_wr.size() == 0) chk("unexpected_write", mem_we, 1'b0);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("mem_wa", mem_wa, e.a);
          chk("mem_wd", mem_wd, e.d);
          expect_done_next = e.last;
        end
      end else begin
        chk("idle_wa_wd_zero", {mem_wa, mem_wd}, 0);
      end
      if (done_valid) begin
        if (exp_done.size() == 0) chk("unexpected_done", done_valid, 1'b0);
        else chk("done_addr", done_addr, exp_done.pop_front());
        last_done = done_addr;
      end
    end
  end

  task automatic list_remove(input int base);
    foreach (alloc_list[i]) begin
      if (alloc_list[i] == base) begin
        alloc_list.delete(i);
        break;
      end
    end
  endtask

  task automatic do_alloc(input logic [95:0] data, input bit fr, input logic [8:0] fa);
    int idx;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (alloc_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk("alloc_ready_timeout", alloc_ready, 1'b1);
      return;
    end
    if (fr) chk("free_ready_with_alloc", free_ready, m_count != 0);
    alloc_valid = 1'b1;
    alloc_data  = data;
    free_valid  = fr;
    free_addr   = fa;
    @(posedge clk);
    if (m_stack.size() != 0) idx = m_stack.pop_back();
    else begin
      idx = m_bp;
      m_bp++;
    end
    if (fr) begin
      m_stack.push_back(int'(fa) / 4);
      list_remove(int'(fa) / 4 * 4);
    end else begin
      m_count++;
    end
    for (int k = 0; k < 4; k++)
      exp_wr.push_back('{a: 9'(idx * 4 + k), d: data[k*24 +: 24], last: (k == 3)});
    exp_done.push_back(9'(idx * 4));
    alloc_list.push_back(idx * 4);
    #1;
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
  endtask

  task automatic do_free(input logic [8:0] fa);
    bit exp_ready;
    exp_ready = (m_count != 0);
    chk("free_ready", free_ready, exp_ready);
    free_valid = 1'b1;
    free_addr  = fa;
    @(posedge clk);
    if (exp_ready) begin
      m_stack.push_back(int'(fa) / 4);
      m_count--;
      list_remove(int'(fa) / 4 * 4);
    end
    #1;
    free_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_wr.size() == 0 && exp_done.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_pending", exp_wr.size() + exp_done.size(), 0);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, count, m_count);
    chk({tag, "_full"}, full, model_full());
    chk({tag, "_alloc_ready"}, alloc_ready, !model_full());
    chk({tag, "_free_ready"}, free_ready, m_count != 0);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
    exp_wr.delete();
    exp_done.delete();
    m_stack.delete();
    alloc_list.delete();
    m_bp    = 0;
    m_count = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_wa_wd", {mem_wa, mem_wd}, 0);
    chk("rst_done", {done_valid, done_addr}, 0);
    chk("rst_count", count, 0);
    chk("rst_free_ready", free_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_alloc_ready", alloc_ready, 1'b1);
    chk("rst_full", full, 1'b0);
  endtask

  function automatic logic [95:0] rnd_data();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    // Three allocations with known words.
    do_reset();
    do_alloc({24'hA00004, 24'hA00003, 24'hA00002, 24'hA00001}, 1'b0, '0);
    do_alloc({24'hA00008, 24'hA00007, 24'hA00006, 24'hA00005}, 1'b0, '0);
    do_alloc({24'hA0000C, 24'hA0000B, 24'hA0000A, 24'hA00009}, 1'b0, '0);
    wait_drain();
    chk("three_last_done", last_done, 9'd8);
    check_state("three");

    // Fill the pool completely.
    do_reset();
    for (int n = 0; n < 128; n++) do_alloc(rnd_data(), 1'b0, '0);
    wait_drain();
    chk("fill_last_done", last_done, 9'd508);
    check_state("fill");
    alloc_valid = 1'b1;
    alloc_data  = rnd_data();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("full_alloc_ready", alloc_ready, 1'b0);
    end
    alloc_valid = 1'b0;

    // LIFO reuse after full.
    do_free(9'h008);
    do_free(9'h1FC);
    check_state("after_free");
    chk("after_free_count", count, 8'd126);
    do_alloc(rnd_data(), 1'b0, '0);
    wait_drain();
    chk("lifo_first", last_done, 9'h1FC);
    do_alloc(rnd_data(), 1'b0, '0);
    wait_drain();
    chk("lifo_second", last_done, 9'h008);

    // Low address bits ignored; frees blocked at zero count.
    do_reset();
    for (int n = 0; n < 3; n++) do_alloc(rnd_data(), 1'b0, '0);
    wait_drain();
    do_free(9'h00B);
    check_state("free_0b");
    do_alloc(rnd_data(), 1'b0, '0);
    wait_drain();
    chk("free_0b_reuse", last_done, 9'h008);
    do_free(9'h000);
    do_free(9'h004);
    do_free(9'h008);
    check_state("empty");
    do_free(9'h010);
    check_state("ignored_free");
    do_alloc(rnd_data(), 1'b0, '0);
    wait_drain();
    chk("after_ignored_free", last_done, 9'h008);

    // Simultaneous free and alloc with stack top index 5.
    do_reset();
    for (int n = 0; n < 8; n++) do_alloc(rnd_data(), 1'b0, '0);
    wait_drain();
    do_free(9'h014);
    do_alloc(rnd_data(), 1'b1, 9'h01C);
    wait_drain();
    chk("simul_alloc", last_done, 9'd20);
    chk("simul_count", count, 8'd7);
    check_state("simul");
    do_alloc(rnd_data(), 1'b0, '0);
    wait_drain();
    chk("simul_reuse", last_done, 9'h01C);

    // Random mix of allocs, frees and combined operations.
    do_reset();
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 2);
      if (r == 0 && !model_full()) begin
        do_alloc(rnd_data(), 1'b0, '0);
      end else if (r == 1 && alloc_list.size() != 0) begin
        do_free(9'(alloc_list[$urandom_range(0, alloc_list.size() - 1)]));
      end else if (r == 2 && alloc_list.size() != 0 && !model_full()) begin
        int pick;
        pick = alloc_list[$urandom_range(0, alloc_list.size() - 1)];
        do_alloc(rnd_data(), 1'b1, 9'(pick) | 9'($urandom_range(0, 3)));
      end else begin
        @(posedge clk); #1;
      end
    end
    wait_drain();
    check_state("random");

    // Reset during the second write cycle.
    do_reset();
    do_alloc(rnd_data(), 1'b0, '0);
    @(posedge clk); #2;
    chk("mid_write_we", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_write_async_drop", mem_we, 1'b0);
    do_reset();
    check_state("post_abort");
    do_alloc(rnd_data(), 1'b0, '0);
    wait_drain();
    chk("post_abort_addr", last_done, 9'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
